// File: rtl/dekatron_pkg.sv
// Shared types and constants for the dekatron step sequencer.
package dekatron_pkg;

   typedef logic [3:0] bcd_t;
   typedef logic [9:0] onehot_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      STEP_HI = 2'd1,
      STEP_LO = 2'd2,
      DONE    = 2'd3
   } step_state_t;

   localparam bcd_t    BCD_MAX   = 4'd9;
   localparam onehot_t POS_RESET = 10'b00_0000_0001;

   // Forward ring distance (target - pos) mod 10 for two valid BCD digits.
   function automatic bcd_t fwd_dist(input bcd_t target, input bcd_t pos);
      logic [4:0] d;
      d = {1'b0, target} + 5'd10 - {1'b0, pos};
      if (d >= 5'd10) d = d - 5'd10;
      return bcd_t'(d);
   endfunction

endpackage

// File: rtl/dekatron_ring.sv
// One-hot 10-position dekatron ring with rotate enable and BCD readout.
module dekatron_ring
   import dekatron_pkg::*;
(
   input  logic    clk,
   input  logic    rst_n,
   input  logic    rotate,
   input  logic    dir,
   output onehot_t pos,
   output bcd_t    pos_bcd
);

   // Rotate the glow one place forward (9 wraps to 0) or backward (0 wraps to 9).
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n)
         pos <= POS_RESET;
      else if (rotate)
         pos <= dir ? {pos[0], pos[9:1]} : {pos[8:0], pos[9]};
   end

   // Encode the one-hot position as a BCD digit.
   always_comb begin
      pos_bcd = '0;
      for (int i = 0; i < 10; i++)
         if (pos[i]) pos_bcd = pos_bcd | bcd_t'(i);
   end

endmodule

// File: rtl/dekatron_step_seq.sv
// Dekatron step sequencer: drives the ring to a requested BCD digit with
// timed step pulses. Define DEKATRON_BIDIR_EN to allow shortest-path
// backward stepping; otherwise stepping is forward only and Dir stays 0.
module dekatron_step_seq
   import dekatron_pkg::*;
#(
   parameter int PULSE_W = 2,
   parameter int GAP_W   = 3
) (
   input  logic       Clk,
   input  logic       Rst_n,
   input  logic       Request,
   input  logic [3:0] Target,
   output logic       Ready,
   output logic       Done,
   output logic       Error,
   output logic       Step,
   output logic       Dir,
   output logic [9:0] Pos,
   output logic [3:0] PosBcd
);

   localparam int TMAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

   step_state_t   state, state_nxt;
   logic [TW-1:0] timer, timer_nxt;
   logic [3:0]    steps, steps_nxt;
   logic          err_q, err_nxt;
   logic          dir_q, dir_nxt;
   logic          rotate;

   bcd_t          fwd;
   bcd_t          n_req;
   logic          back_req;
   logic          valid_req;

   dekatron_ring u_ring (
      .clk     (Clk),
      .rst_n   (Rst_n),
      .rotate  (rotate),
      .dir     (dir_q),
      .pos     (Pos),
      .pos_bcd (PosBcd)
   );

   // Step count and direction for a request arriving from the current position.
   always_comb begin
      valid_req = (Target <= BCD_MAX);
      fwd       = fwd_dist(Target, PosBcd);
`ifdef DEKATRON_BIDIR_EN
      // Backward only when strictly shorter; a distance of 5 stays forward.
      back_req  = ((4'd10 - fwd) < fwd);
      n_req     = back_req ? (4'd10 - fwd) : fwd;
`else
      back_req  = 1'b0;
      n_req     = fwd;
`endif
   end

   // Next-state logic for the FSM, phase timer and remaining-step counter.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      state_nxt = state;
      timer_nxt = timer;
      steps_nxt = steps;
      err_nxt   = err_q;
      dir_nxt   = dir_q;
      rotate    = 1'b0;
      case (state)
         IDLE: begin
            if (Request) begin
               timer_nxt = '0;
               err_nxt   = !valid_req;
               dir_nxt   = valid_req && back_req;
               if (!valid_req || n_req == 4'd0) begin
                  steps_nxt = '0;
                  state_nxt = DONE;
               end else begin
                  steps_nxt = n_req;
                  state_nxt = STEP_HI;
               end
            end
         end
         STEP_HI: begin
            if (timer == TW'(PULSE_W - 1)) begin
               timer_nxt = '0;
               rotate    = 1'b1;
               steps_nxt = steps - 4'd1;
               state_nxt = STEP_LO;
            end else begin
               timer_nxt = timer + 1'b1;
            end
         end
         STEP_LO: begin
            if (timer == TW'(GAP_W - 1)) begin
               timer_nxt = '0;
               state_nxt = (steps == 4'd0) ? DONE : STEP_HI;
            end else begin
               timer_nxt = timer + 1'b1;
            end
         end
         DONE: begin
            err_nxt   = 1'b0;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State registers and registered outputs decoded from the next state.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state <= IDLE;
         timer <= '0;
         steps <= '0;
         err_q <= 1'b0;
         dir_q <= 1'b0;
         Ready <= 1'b1;
         Step  <= 1'b0;
         Done  <= 1'b0;
         Error <= 1'b0;
      end else begin
         state <= state_nxt;
         timer <= timer_nxt;
         steps <= steps_nxt;
         err_q <= err_nxt;
         dir_q <= dir_nxt;
         Ready <= (state_nxt == IDLE);
         Step  <= (state_nxt == STEP_HI);
         Done  <= (state_nxt == DONE);
         Error <= (state_nxt == DONE) && err_nxt;
      end
   end

   assign Dir = dir_q;

endmodule

// File: tb/tb_dekatron_step_seq.sv
// Testbench for dekatron_step_seq: table of directed loads plus hand-written
// sequences for an ignored mid-operation request and a mid-operation reset.
module tb_dekatron_step_seq;
   import dekatron_pkg::*;

   localparam int PW = 2;
   localparam int GW = 3;

   typedef struct {
      logic [3:0] target;
      int         n_steps;
      int         done_cyc;
      int         exp_bcd;
      bit         err;
      bit         dir;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       request = 1'b0;
   logic [3:0] target = 4'd0;
   logic       ready, done, error, step, dir;
   logic [9:0] pos;
   logic [3:0] pos_bcd;

   int n_tests = 0;
   int n_fail  = 0;
   vec_t vecs[9];

   dekatron_step_seq #(.PULSE_W(PW), .GAP_W(GW)) dut (
      .Clk     (clk),
      .Rst_n   (rst_n),
      .Request (request),
      .Target  (target),
      .Ready   (ready),
      .Done    (done),
      .Error   (error),
      .Step    (step),
      .Dir     (dir),
      .Pos     (pos),
      .PosBcd  (pos_bcd)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic onehot_t rot(input onehot_t p, input bit back);
      return back ? {p[0], p[9:1]} : {p[8:0], p[9]};
   endfunction

   // One load: request at t0, then sample #1 after each edge (cycle index 1 = just after t0).
   task automatic run_op(input vec_t v, input int idx, input bit inject);
      onehot_t start_pos;
      int      cyc, rises, first_rise, last_rise, bad_gap;
      logic    prev_step;
      @(negedge clk);
      start_pos = pos;
      request = 1'b1;
      target  = v.target;
      @(posedge clk); #1;
      request = 1'b0;
      cyc = 1; rises = 0; first_rise = 0; last_rise = 0; bad_gap = 0; prev_step = 1'b0;
      check($sformatf("v%0d ready_low", idx), ready, 1'b0);
      while (1) begin
         if (step && !prev_step) begin
            rises++;
            if (first_rise == 0) first_rise = cyc;
            else if (cyc - last_rise != PW + GW) bad_gap++;
            last_rise = cyc;
         end
         prev_step = step;
         if (v.n_steps > 0 && cyc == PW + 1)
            check($sformatf("v%0d pos_after_first_step", idx), pos, rot(start_pos, v.dir));
         if (inject && cyc == 4) begin
            request = 1'b1;
            target  = 4'd9;
         end else begin
            request = 1'b0;
         end
         if (done || cyc >= 200) break;
         @(posedge clk); #1;
         cyc++;
      end
      request = 1'b0;
      check($sformatf("v%0d done_cycle", idx), done ? cyc : -1, v.done_cyc);
      check($sformatf("v%0d step_count", idx), rises, v.n_steps);
      check($sformatf("v%0d first_step_cycle", idx), first_rise, (v.n_steps > 0) ? 1 : 0);
      check($sformatf("v%0d step_period_errs", idx), bad_gap, 0);
      check($sformatf("v%0d error", idx), error, v.err);
      check($sformatf("v%0d dir", idx), dir, v.dir);
      check($sformatf("v%0d pos", idx), pos, onehot_t'(10'd1 << v.exp_bcd));
      check($sformatf("v%0d pos_bcd", idx), pos_bcd, v.exp_bcd);
      @(posedge clk); #1;
      check($sformatf("v%0d done_one_cycle", idx), done, 1'b0);
      check($sformatf("v%0d ready_back", idx), ready, 1'b1);
      check($sformatf("v%0d error_clear", idx), error, 1'b0);
   endtask

   initial begin
      int   rises, cyc, dones, idle_steps;
      logic prev;

`ifdef DEKATRON_BIDIR_EN
      vecs[0] = '{4'd7, 3, 16, 7, 1'b0, 1'b1};
      vecs[1] = '{4'd8, 1,  6, 8, 1'b0, 1'b0};
      vecs[2] = '{4'd2, 4, 21, 2, 1'b0, 1'b0};
      vecs[3] = '{4'd5, 3, 16, 5, 1'b0, 1'b0};
      vecs[4] = '{4'd5, 0,  1, 5, 1'b0, 1'b0};
      vecs[5] = '{4'hC, 0,  1, 5, 1'b1, 1'b0};
      vecs[6] = '{4'd4, 1,  6, 4, 1'b0, 1'b1};
      vecs[7] = '{4'd0, 4, 21, 0, 1'b0, 1'b1};
      vecs[8] = '{4'd5, 5, 26, 5, 1'b0, 1'b0};
`else
      vecs[0] = '{4'd7, 7, 36, 7, 1'b0, 1'b0};
      vecs[1] = '{4'd8, 1,  6, 8, 1'b0, 1'b0};
      vecs[2] = '{4'd2, 4, 21, 2, 1'b0, 1'b0};
      vecs[3] = '{4'd5, 3, 16, 5, 1'b0, 1'b0};
      vecs[4] = '{4'd5, 0,  1, 5, 1'b0, 1'b0};
      vecs[5] = '{4'hC, 0,  1, 5, 1'b1, 1'b0};
      vecs[6] = '{4'd4, 9, 46, 4, 1'b0, 1'b0};
      vecs[7] = '{4'd0, 6, 31, 0, 1'b0, 1'b0};
      vecs[8] = '{4'd5, 5, 26, 5, 1'b0, 1'b0};
`endif

      // Reset state.
      #12;
      check("reset ready", ready, 1'b1);
      check("reset step", step, 1'b0);
      check("reset done", done, 1'b0);
      check("reset error", error, 1'b0);
      check("reset dir", dir, 1'b0);
      check("reset pos", pos, 10'b00_0000_0001);
      check("reset pos_bcd", pos_bcd, 4'd0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) run_op(vecs[i], i, 1'b0);

      // Request pulsed mid-operation with a different target is ignored (5 -> 3).
`ifdef DEKATRON_BIDIR_EN
      run_op('{4'd3, 2, 11, 3, 1'b0, 1'b1}, 9, 1'b1);
`else
      run_op('{4'd3, 8, 41, 3, 1'b0, 1'b0}, 9, 1'b1);
`endif
      dones = 0; idle_steps = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         dones += int'(done);
         idle_steps += int'(step);
      end
      check("ignored_req extra_done", dones, 0);
      check("ignored_req extra_steps", idle_steps, 0);
      check("ignored_req pos", pos, 10'b00_0000_1000);

      // Reset during the 3rd STEP_HI of a 0 -> 7 load.
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      request = 1'b1;
      target  = 4'd7;
      @(posedge clk); #1;
      request = 1'b0;
      rises = 0; cyc = 0; prev = 1'b0;
      while (rises < 3 && cyc < 100) begin
         if (step && !prev) rises++;
         prev = step;
         if (rises < 3) begin
            @(posedge clk); #1;
            cyc++;
         end
      end
      check("midreset reached_third_step", rises, 3);
      check("midreset step_high_before", step, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("midreset step", step, 1'b0);
      check("midreset pos", pos, 10'b00_0000_0001);
      check("midreset ready", ready, 1'b1);
      @(negedge clk); rst_n = 1'b1;
      dones = 0; idle_steps = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         dones += int'(done);
         idle_steps += int'(step);
      end
      check("midreset no_done", dones, 0);
      check("midreset no_steps", idle_steps, 0);
      check("midreset ready_after", ready, 1'b1);
      check("midreset pos_bcd", pos_bcd, 4'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
